// File: rtl/sft_ex_scheduler_pkg.sv
// Shared constants and the request record for the shift execution scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sft_sched_pkg;

    // Bit positions inside a request op field
    localparam int OP_L = 0;
    localparam int OP_R = 1;
    localparam int OP_A = 2;
    localparam int OP_W = 3;

    localparam int NPORT = 2;

    // Field widths of the request record, sized for the widest build (RV64, wide tags)
    localparam int MAX_XLEN  = 64;
    localparam int MAX_OPW   = 4;
    localparam int MAX_SW    = 6;
    localparam int MAX_TAG_W = 16;

    typedef struct packed {
        logic [MAX_OPW-1:0]   op;
        logic [MAX_XLEN-1:0]  s1;
        logic [MAX_SW-1:0]    s2;
        logic [MAX_TAG_W-1:0] tag;
    } sftReq_t;

endpackage

// File: rtl/sft_ex_scheduler_if.sv
// Request/result bundle between two requesters, the shift scheduler and its consumer.
// Latency: none (wiring only).
// Backpressure: requesters hold iReq* until oReqRdy; consumer stalls results with iRsltRdy.
interface sft_ex_scheduler_if
    import sft_sched_pkg::*;
#(
    parameter int RV64  = 1,
    parameter int TAG_W = 4
) ();

    localparam int XLEN = 32 * (RV64 + 1);
    localparam int OPW  = 3 + RV64;
    localparam int SW   = 5 + RV64;

    logic [NPORT-1:0]            iReqVld;
    logic [NPORT-1:0]            oReqRdy;
    logic [NPORT-1:0][OPW-1:0]   iReqOp;
    logic [NPORT-1:0][XLEN-1:0]  iReqS1;
    logic [NPORT-1:0][SW-1:0]    iReqS2;
    logic [NPORT-1:0][TAG_W-1:0] iReqTag;

    logic                        oRsltVld;
    logic                        iRsltRdy;
    logic [XLEN-1:0]             oRslt;
    logic [TAG_W-1:0]            oRsltTag;
    logic                        oRsltPort;
    logic                        oRsltErr;

    modport master (
        output iReqVld, iReqOp, iReqS1, iReqS2, iReqTag, iRsltRdy,
        input  oReqRdy, oRsltVld, oRslt, oRsltTag, oRsltPort, oRsltErr
    );

    modport slave (
        input  iReqVld, iReqOp, iReqS1, iReqS2, iReqTag, iRsltRdy,
        output oReqRdy, oRsltVld, oRslt, oRsltTag, oRsltPort, oRsltErr
    );

endinterface

// File: rtl/sft_ex_scheduler_core.sv
// Combinational shifter: SLL/SRL/SRA, .W variants and illegal-op detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the surrounding pipeline registers decide when results are taken.
module sft_core
    import sft_sched_pkg::*;
#(
    parameter int RV64 = 1
) (
    input  logic [3+RV64-1:0]      op,
    input  logic [32*(RV64+1)-1:0] s1,
    input  logic [5+RV64-1:0]      s2,
    output logic [32*(RV64+1)-1:0] rslt,
    output logic                   err
);

    localparam int XLEN = 32 * (RV64 + 1);
    localparam int SW   = 5 + RV64;

    logic            isLeft;
    logic            isRight;
    logic            isArith;
    logic            isW;
    logic            wBadAmt;
    logic            illegal;
    logic            fill;
    logic [SW-1:0]   effAmt;
    logic [XLEN-1:0] wSrc;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] wRes;

    assign isLeft  = op[OP_L];
    assign isRight = op[OP_R];
    assign isArith = op[OP_A];

    // Word ops only exist on the 64-bit datapath: low word in, 5-bit amount, sign-extended word out
    generate
        if (RV64 != 0) begin : gRv64
            assign isW     = op[OP_W];
            assign wBadAmt = op[OP_W] & s2[SW-1];
            assign wSrc    = {{(XLEN-32){isRight & isArith & s1[31]}}, s1[31:0]};
            assign effAmt  = op[OP_W] ? {1'b0, s2[4:0]} : s2;
            assign wRes    = {{(XLEN-32){raw[31]}}, raw[31:0]};
        end else begin : gRv32
            assign isW     = 1'b0;
            assign wBadAmt = 1'b0;
            assign wSrc    = s1;
            assign effAmt  = s2;
            assign wRes    = raw;
        end
    endgenerate

    function automatic logic [XLEN-1:0] bitRev(input logic [XLEN-1:0] x);
        for (int i = 0; i < XLEN; i++) begin
            bitRev[i] = x[XLEN-1-i];
        end
    endfunction

    // One right shifter serves all ops; left shifts run on the bit-reversed operand
    always_comb begin
        operand = isW ? wSrc : s1;
        if (isLeft) begin
            operand = bitRev(operand);
        end
        fill    = isRight & isArith & operand[XLEN-1];
        shifted = XLEN'($signed({fill, operand}) >>> effAmt);
        raw     = isLeft ? bitRev(shifted) : shifted;
    end

    assign illegal = (isLeft & isRight) | (~isLeft & ~isRight) | (isLeft & isArith) | wBadAmt;
    assign rslt    = illegal ? '0 : (isW ? wRes : raw);
    assign err     = illegal;

endmodule

// File: rtl/sft_ex_scheduler.sv
// Two-port shift scheduler: arbitrate into S0, shift, register the result in S1 (SFT_EX_SCHED_RR_EN selects round-robin, else port 0 priority).
// Latency: accept to oRsltVld is 2 cycles; one op per cycle sustained while iRsltRdy is high.
// Backpressure: iRsltRdy low freezes S1, S0 fills, then oReqRdy drops; results are held stable.
module sft_ex_scheduler
    import sft_sched_pkg::*;
#(
    parameter int RV64  = 1,
    parameter int TAG_W = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    sft_ex_scheduler_if.slave     bus
);

    localparam int XLEN = 32 * (RV64 + 1);
    localparam int OPW  = 3 + RV64;
    localparam int SW   = 5 + RV64;

    logic             s0Vld;
    sftReq_t          s0Req;
    logic             s0Port;

    logic             s1Vld;
    logic [XLEN-1:0]  s1Rslt;
    logic [TAG_W-1:0] s1Tag;
    logic             s1Port;
    logic             s1Err;

    logic             s1Load;
    logic             s0CanLoad;
    logic [NPORT-1:0] grant;
    logic [NPORT-1:0] reqRdy;
    logic             grantPort;
    logic             accept;
    sftReq_t          reqSel;
    logic [XLEN-1:0]  coreRslt;
    logic             coreErr;
    logic             unusedReqBits;

    assign s1Load    = s0Vld & (~s1Vld | bus.iRsltRdy);
    assign s0CanLoad = ~s0Vld | s1Load;

`ifdef SFT_EX_SCHED_RR_EN
    logic rrPtr;

    // Round-robin pointer: after a grant the other port gets precedence
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            rrPtr <= 1'b0;
        end else if (accept) begin
            rrPtr <= ~grantPort;
        end
    end

    // Contention goes to the pointed port; a lone requester always wins
    always_comb begin
        grant = '0;
        if (&bus.iReqVld) begin
            grant[rrPtr] = 1'b1;
        end else begin
            grant = bus.iReqVld;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it is requesting
    always_comb begin
        grant = bus.iReqVld[0] ? 2'b01 : (bus.iReqVld & 2'b10);
    end
`endif

    assign grantPort   = grant[1];
    assign reqRdy      = grant & {NPORT{s0CanLoad & iRst_n}};
    assign bus.oReqRdy = reqRdy;
    assign accept      = |(bus.iReqVld & reqRdy);

    // Capture the granted port's request into the widest-build record
    always_comb begin
        reqSel               = '0;
        reqSel.op[OPW-1:0]   = bus.iReqOp[grantPort];
        reqSel.s1[XLEN-1:0]  = bus.iReqS1[grantPort];
        reqSel.s2[SW-1:0]    = bus.iReqS2[grantPort];
        reqSel.tag[TAG_W-1:0] = bus.iReqTag[grantPort];
    end

    // S0: holds the accepted operands until S1 can take the shifted result
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s0Vld  <= 1'b0;
            s0Req  <= '0;
            s0Port <= 1'b0;
        end else if (accept) begin
            s0Vld  <= 1'b1;
            s0Req  <= reqSel;
            s0Port <= grantPort;
        end else if (s1Load) begin
            s0Vld  <= 1'b0;
        end
    end

    sft_core #(
        .RV64 (RV64)
    ) uCore (
        .op   (s0Req.op[OPW-1:0]),
        .s1   (s0Req.s1[XLEN-1:0]),
        .s2   (s0Req.s2[SW-1:0]),
        .rslt (coreRslt),
        .err  (coreErr)
    );

    // Record fields above the configured widths stay zero and are intentionally not consumed
    assign unusedReqBits = ^s0Req;

    // S1: result register, frozen while the consumer stalls
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s1Vld  <= 1'b0;
            s1Rslt <= '0;
            s1Tag  <= '0;
            s1Port <= 1'b0;
            s1Err  <= 1'b0;
        end else if (s1Load) begin
            s1Vld  <= 1'b1;
            s1Rslt <= coreRslt;
            s1Tag  <= s0Req.tag[TAG_W-1:0];
            s1Port <= s0Port;
            s1Err  <= coreErr;
        end else if (bus.iRsltRdy) begin
            s1Vld  <= 1'b0;
        end
    end

    assign bus.oRsltVld  = s1Vld;
    assign bus.oRslt     = s1Rslt;
    assign bus.oRsltTag  = s1Tag;
    assign bus.oRsltPort = s1Port;
    assign bus.oRsltErr  = s1Err;

endmodule

// File: tb/tb_sft_ex_scheduler.sv
// Randomized scoreboard bench for sft_ex_scheduler with directed corner cases.
// Latency: checks 2-cycle accept-to-result timing and stall-aware result timing.
// Backpressure: drives random iRsltRdy stalls and holds requests until accepted.
`timescale 1ns/1ps
module tb_sft_ex_scheduler;
    import sft_sched_pkg::*;

    localparam int RV64  = 1;
    localparam int TAG_W = 4;

    logic iClk;
    logic iRst_n;

    sft_ex_scheduler_if #(.RV64(RV64), .TAG_W(TAG_W)) bus ();

    sft_ex_scheduler #(.RV64(RV64), .TAG_W(TAG_W)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [63:0] rslt;
        logic [3:0]  tag;
        logic        port;
        logic        err;
        int          acc;
    } expT;

    expT        sbQ[$];
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         lastPop  = -100;
    logic       ptrModel = 1'b0;
    logic       justRst  = 1'b0;
    logic [1:0] accepted = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference shifter from the op definitions: {err, result}
    function automatic logic [64:0] refShift(input logic [3:0] op, input logic [63:0] s1, input logic [5:0] s2);
        logic        l, r, a, w;
        logic [31:0] x, r32;
        logic [4:0]  amt;
        l = op[0]; r = op[1]; a = op[2]; w = op[3];
        if (!(l ^ r) || (l && a) || (w && s2[5])) return {1'b1, 64'd0};
        if (w) begin
            x   = s1[31:0];
            amt = s2[4:0];
            if (l)      r32 = x << amt;
            else if (a) r32 = $signed(x) >>> amt;
            else        r32 = x >> amt;
            return {1'b0, {32{r32[31]}}, r32};
        end
        if (l)      return {1'b0, s1 << s2};
        else if (a) return {1'b0, 64'($signed(s1) >>> s2)};
        return {1'b0, s1 >> s2};
    endfunction

    // Which port the arbiter should favour for a given request pattern
    function automatic logic [1:0] expGrant(input logic [1:0] v, input logic p);
`ifdef SFT_EX_SCHED_RR_EN
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
`else
        if (v[0]) return 2'b01;
        return v;
`endif
    endfunction

    // Monitor: predicts ready/valid, records accepts into the scoreboard, checks results in order
    always @(negedge iClk) begin
        logic [1:0]  expRdy;
        logic        expVld;
        int          readyAt;
        logic [64:0] m;
        expT         e;
        cyc++;
        accepted = 2'b00;
        if (!iRst_n) begin
            chk("rdy_in_reset", 64'(bus.oReqRdy), 64'd0);
            sbQ.delete();
            ptrModel = 1'b0;
            lastPop  = -100;
            justRst  = 1'b1;
        end else begin
            if (justRst) begin
                chk("rst_vld",  64'(bus.oRsltVld),  64'd0);
                chk("rst_rslt", bus.oRslt,          64'd0);
                chk("rst_tag",  64'(bus.oRsltTag),  64'd0);
                chk("rst_port", 64'(bus.oRsltPort), 64'd0);
                chk("rst_err",  64'(bus.oRsltErr),  64'd0);
                justRst = 1'b0;
            end
            expRdy = (sbQ.size() < 2 || bus.iRsltRdy) ? expGrant(bus.iReqVld, ptrModel) : 2'b00;
            chk("req_rdy", 64'(bus.oReqRdy), 64'(expRdy));
            expVld = 1'b0;
            if (sbQ.size() > 0) begin
                readyAt = sbQ[0].acc + 2;
                if (lastPop + 1 > readyAt) readyAt = lastPop + 1;
                expVld = (cyc >= readyAt);
            end
            chk("rslt_vld", 64'(bus.oRsltVld), 64'(expVld));
            if (bus.oRsltVld && sbQ.size() > 0) begin
                chk("rslt_data", bus.oRslt,          sbQ[0].rslt);
                chk("rslt_tag",  64'(bus.oRsltTag),  64'(sbQ[0].tag));
                chk("rslt_port", 64'(bus.oRsltPort), 64'(sbQ[0].port));
                chk("rslt_err",  64'(bus.oRsltErr),  64'(sbQ[0].err));
                if (bus.iRsltRdy) begin
                    void'(sbQ.pop_front());
                    lastPop = cyc;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.iReqVld[i] && bus.oReqRdy[i]) begin
                    m      = refShift(bus.iReqOp[i], bus.iReqS1[i], bus.iReqS2[i]);
                    e.rslt = m[63:0];
                    e.err  = m[64];
                    e.tag  = bus.iReqTag[i];
                    e.port = i[0];
                    e.acc  = cyc;
                    sbQ.push_back(e);
                    accepted[i] = 1'b1;
`ifdef SFT_EX_SCHED_RR_EN
                    ptrModel = ~i[0];
`endif
                end
            end
        end
    end

    function automatic logic [3:0] randOp();
        case ($urandom_range(0, 7))
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0110;
            3:       return 4'b1001;
            4:       return 4'b1010;
            5:       return 4'b1110;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic newReq(input int p);
        bus.iReqOp[p]  = randOp();
        bus.iReqS1[p]  = ($urandom_range(0, 3) == 0) ? 64'h8000_0000_8000_0000 : {$urandom, $urandom};
        bus.iReqS2[p]  = 6'($urandom_range(0, 63));
        bus.iReqTag[p] = 4'($urandom_range(0, 15));
    endtask

    task automatic waitDrain(input int bound);
        int n = 0;
        while (sbQ.size() != 0 && n < bound) begin
            @(negedge iClk);
            n++;
        end
        chk("drain_outstanding", 64'(sbQ.size()), 64'd0);
        @(posedge iClk); #1;
    endtask

    task automatic directed(input int p, input logic [3:0] op, input logic [63:0] s1, input logic [5:0] s2,
                            input logic [3:0] tag, input logic [63:0] expR, input logic expE);
        @(posedge iClk); #1;
        bus.iRsltRdy   = 1'b1;
        bus.iReqOp[p]  = op;
        bus.iReqS1[p]  = s1;
        bus.iReqS2[p]  = s2;
        bus.iReqTag[p] = tag;
        bus.iReqVld    = 2'b00;
        bus.iReqVld[p] = 1'b1;
        @(negedge iClk);
        chk("dir_accept", 64'(bus.oReqRdy[p]), 64'd1);
        @(posedge iClk); #1;
        bus.iReqVld = 2'b00;
        @(negedge iClk);
        chk("dir_vld_cycle1", 64'(bus.oRsltVld), 64'd0);
        @(negedge iClk);
        chk("dir_vld_cycle2", 64'(bus.oRsltVld),  64'd1);
        chk("dir_rslt",       bus.oRslt,          expR);
        chk("dir_err",        64'(bus.oRsltErr),  64'(expE));
        chk("dir_tag",        64'(bus.oRsltTag),  64'(tag));
        chk("dir_port",       64'(bus.oRsltPort), 64'(p));
        @(posedge iClk); #1;
    endtask

    initial begin
        int nAcc;
        int nG;
        int seq [8];
        iRst_n       = 1'b0;
        bus.iReqVld  = '0;
        bus.iReqOp   = '0;
        bus.iReqS1   = '0;
        bus.iReqS2   = '0;
        bus.iReqTag  = '0;
        bus.iRsltRdy = 1'b1;
        repeat (3) @(posedge iClk);
        #1 iRst_n = 1'b1;

        // Directed values: SRA, SRAW, SLLW, illegal left+arith
        directed(0, 4'b0110, 64'h8000_0000_0000_0000, 6'd4,  4'h1, 64'hF800_0000_0000_0000, 1'b0);
        directed(1, 4'b1110, 64'h0000_0000_8000_0000, 6'd1,  4'h2, 64'hFFFF_FFFF_C000_0000, 1'b0);
        directed(0, 4'b1001, 64'h0000_0000_0000_0001, 6'd31, 4'h5, 64'hFFFF_FFFF_8000_0000, 1'b0);
        directed(1, 4'b0101, 64'h1234_5678_9ABC_DEF0, 6'd7,  4'h3, 64'd0,                  1'b1);

        // Consumer stalled for 5 cycles under continuous requests: only two fit
        @(posedge iClk); #1;
        bus.iRsltRdy = 1'b0;
        newReq(0);
        bus.iReqVld = 2'b01;
        nAcc = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge iClk); #1;
            if (accepted[0]) begin
                nAcc++;
                newReq(0);
            end
        end
        chk("stall_accepts", 64'(nAcc), 64'd2);
        bus.iReqVld  = 2'b00;
        bus.iRsltRdy = 1'b1;
        waitDrain(50);

        // Fill both stages, then pulse reset: nothing stale may come out
        bus.iRsltRdy = 1'b0;
        newReq(1);
        bus.iReqVld = 2'b10;
        nAcc = 0;
        for (int k = 0; k < 10 && nAcc < 2; k++) begin
            @(posedge iClk); #1;
            if (accepted[1]) begin
                nAcc++;
                newReq(1);
            end
        end
        bus.iReqVld = 2'b00;
        chk("fill_accepts", 64'(nAcc), 64'd2);
        @(posedge iClk); #1;
        iRst_n = 1'b0;
        @(posedge iClk); #1;

        // Both ports requesting from the first cycle out of reset
        iRst_n       = 1'b1;
        bus.iRsltRdy = 1'b1;
        newReq(0);
        newReq(1);
        bus.iReqVld = 2'b11;
        nG = 0;
        for (int k = 0; k < 8; k++) seq[k] = 9;
        for (int k = 0; k < 8; k++) begin
            @(posedge iClk); #1;
            if (accepted[0]) begin
                seq[nG] = 0; nG++; newReq(0);
            end else if (accepted[1]) begin
                seq[nG] = 1; nG++; newReq(1);
            end
        end
        bus.iReqVld = 2'b00;
        chk("arb_grant_count", 64'(nG), 64'd8);
        for (int k = 0; k < 8; k++) begin
`ifdef SFT_EX_SCHED_RR_EN
            chk("arb_grant_order", 64'(seq[k]), 64'(k % 2));
`else
            chk("arb_grant_order", 64'(seq[k]), 64'd0);
`endif
        end
        waitDrain(50);

        // Random traffic with random consumer stalls and one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            @(posedge iClk); #1;
            iRst_n = (c == 1500) ? 1'b0 : 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (bus.iReqVld[p]) begin
                    if (accepted[p]) begin
                        if ($urandom_range(0, 3) != 0) newReq(p);
                        else bus.iReqVld[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    newReq(p);
                    bus.iReqVld[p] = 1'b1;
                end
            end
            bus.iRsltRdy = ($urandom_range(0, 9) < 7);
        end
        @(posedge iClk); #1;
        iRst_n       = 1'b1;
        bus.iReqVld  = 2'b00;
        bus.iRsltRdy = 1'b1;
        waitDrain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
